tblock_dispatcher: RTL and testbench

- Sequences one kernel launch (grid) onto a compute unit's warp allocation interface.
- Accepts a launch descriptor: start PC, data/parameter address, thread-block count.
- Issues one allocation per thread block with an incrementing block index and a unique block id taken from a free-id pool.
- Recycles ids on thread-block completion and reports grid completion upstream once every block has retired.

---
 rtl/tblock_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_tblock_dispatcher.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tblock_dispatcher.sv
// Thread-block dispatcher: walks one grid onto the warp allocator, recycling block ids on completion.
// Optional stall counter on stall_cycles_o is built when BGPU_DISPATCH_PERF_EN is defined.
module tblock_dispatcher #(
    parameter int PcWidth       = 32,
    parameter int AddressWidth  = 32,
    parameter int TblockIdxBits = 4,
    parameter int TblockIdBits  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     launch_valid_i,
    output logic                     launch_ready_o,
    input  logic [PcWidth-1:0]       launch_pc_i,
    input  logic [AddressWidth-1:0]  launch_dp_addr_i,
    input  logic [TblockIdxBits:0]   launch_num_tblocks_i,
    output logic                     grid_done_valid_o,
    input  logic                     grid_done_ready_i,
    input  logic                     warp_free_i,
    output logic                     allocate_warp_o,
    output logic [PcWidth-1:0]       allocate_pc_o,
    output logic [AddressWidth-1:0]  allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
    output logic [TblockIdBits-1:0]  allocate_tblock_id_o,
    input  logic                     tblock_done_i,
    input  logic [TblockIdBits-1:0]  tblock_done_id_i,
    output logic                     tblock_done_ready_o,
    output logic                     busy_o,
    output logic [31:0]              stall_cycles_o
);

    localparam int NumIds = 1 << TblockIdBits;
    localparam logic [TblockIdxBits:0] IssuedOne = (TblockIdxBits+1)'(1);
    localparam logic [TblockIdBits:0]  OutOne    = (TblockIdBits+1)'(1);
    localparam logic [TblockIdxBits:0] MaxBlocks = (TblockIdxBits+1)'(1 << TblockIdxBits);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [NumIds-1:0]        id_used_q, id_used_d;
    logic [TblockIdxBits:0]   issued_q, issued_inc;
    logic [TblockIdBits:0]    outstanding_q, outstanding_d;
    logic [TblockIdxBits:0]   num_q;
    logic [PcWidth-1:0]       pc_q;
    logic [AddressWidth-1:0]  dp_addr_q;
    logic [TblockIdBits-1:0]  free_id;
    logic                     free_found;
    logic                     alloc;
    logic                     launch_fire;
    logic                     done_fire;

    // Handshakes: launch and grid-done transfer when valid && ready in the same cycle;
    // allocation is fire-and-forget; completions are always accepted outside reset.
    assign launch_fire = !rst_i && (state_q == IDLE) && launch_valid_i;
    assign done_fire   = !rst_i && tblock_done_i;
    assign alloc       = !rst_i && (state_q == DISPATCH) && warp_free_i && free_found;
    assign issued_inc  = issued_q + IssuedOne;

    // Lowest clear bit of the registered bitmap; a same-cycle free is not visible here.
    always_comb begin
        free_id    = '0;
        free_found = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            if (!free_found && !id_used_q[i]) begin
                free_id    = TblockIdBits'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        id_used_d = id_used_q;
        if (done_fire) id_used_d[tblock_done_id_i] = 1'b0;
        if (alloc)     id_used_d[free_id] = 1'b1;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({alloc, done_fire})
            2'b10:   outstanding_d = outstanding_q + OutOne;
            2'b01:   outstanding_d = outstanding_q - OutOne;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (launch_valid_i)
                          state_d = (launch_num_tblocks_i == '0) ? DONE : DISPATCH;
            DISPATCH: if (alloc && (issued_inc == num_q)) state_d = DRAIN;
            DRAIN:    if (outstanding_q == '0) state_d = DONE;
            DONE:     if (grid_done_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        launch_ready_o        = 1'b0;
        grid_done_valid_o     = 1'b0;
        tblock_done_ready_o   = 1'b0;
        busy_o                = 1'b0;
        allocate_warp_o       = 1'b0;
        allocate_pc_o         = '0;
        allocate_dp_addr_o    = '0;
        allocate_tblock_idx_o = '0;
        allocate_tblock_id_o  = '0;
        if (!rst_i) begin
            launch_ready_o      = (state_q == IDLE);
            grid_done_valid_o   = (state_q == DONE);
            tblock_done_ready_o = 1'b1;
            busy_o              = (state_q != IDLE);
            allocate_warp_o     = alloc;
            if (alloc) begin
                allocate_pc_o         = pc_q;
                allocate_dp_addr_o    = dp_addr_q;
                allocate_tblock_idx_o = issued_q[TblockIdxBits-1:0];
                allocate_tblock_id_o  = free_id;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_used_q     <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            num_q         <= '0;
            pc_q          <= '0;
            dp_addr_q     <= '0;
        end else begin
            if (launch_fire) begin
                num_q     <= launch_num_tblocks_i;
                pc_q      <= launch_pc_i;
                dp_addr_q <= launch_dp_addr_i;
                issued_q  <= '0;
            end else if (alloc) begin
                issued_q <= issued_inc;
            end
            id_used_q     <= id_used_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifdef BGPU_DISPATCH_PERF_EN
    logic [31:0] stall_q;

    // Counts DISPATCH cycles that could not allocate, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                  stall_q <= '0;
        else if (launch_fire)                       stall_q <= '0;
        else if ((state_q == DISPATCH) && !alloc &&
                 (stall_q != 32'hFFFF_FFFF))        stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles_o = rst_i ? 32'd0 : stall_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (launch_fire) assert (launch_num_tblocks_i <= MaxBlocks);
            if (done_fire)   assert (id_used_q[tblock_done_id_i]);
            if (done_fire && !alloc) assert (outstanding_q != '0);
            if (done_fire)   assert (!((state_q == IDLE) && (outstanding_q == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_tblock_dispatcher.sv
// Directed bench for tblock_dispatcher with a 2-bit id pool; expected values are hand-derived.
// Stall-count expectations follow BGPU_DISPATCH_PERF_EN as the RTL is built.
module tb_tblock_dispatcher;

    localparam int PcW  = 32;
    localparam int AdW  = 32;
    localparam int IdxB = 4;
    localparam int IdB  = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            launch_valid_i;
    logic            launch_ready_o;
    logic [PcW-1:0]  launch_pc_i;
    logic [AdW-1:0]  launch_dp_addr_i;
    logic [IdxB:0]   launch_num_tblocks_i;
    logic            grid_done_valid_o;
    logic            grid_done_ready_i;
    logic            warp_free_i;
    logic            allocate_warp_o;
    logic [PcW-1:0]  allocate_pc_o;
    logic [AdW-1:0]  allocate_dp_addr_o;
    logic [IdxB-1:0] allocate_tblock_idx_o;
    logic [IdB-1:0]  allocate_tblock_id_o;
    logic            tblock_done_i;
    logic [IdB-1:0]  tblock_done_id_i;
    logic            tblock_done_ready_o;
    logic            busy_o;
    logic [31:0]     stall_cycles_o;

    int vectors = 0;
    int miscompares = 0;

    tblock_dispatcher #(
        .PcWidth(PcW), .AddressWidth(AdW), .TblockIdxBits(IdxB), .TblockIdBits(IdB)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .launch_valid_i(launch_valid_i), .launch_ready_o(launch_ready_o),
        .launch_pc_i(launch_pc_i), .launch_dp_addr_i(launch_dp_addr_i),
        .launch_num_tblocks_i(launch_num_tblocks_i),
        .grid_done_valid_o(grid_done_valid_o), .grid_done_ready_i(grid_done_ready_i),
        .warp_free_i(warp_free_i), .allocate_warp_o(allocate_warp_o),
        .allocate_pc_o(allocate_pc_o), .allocate_dp_addr_o(allocate_dp_addr_o),
        .allocate_tblock_idx_o(allocate_tblock_idx_o), .allocate_tblock_id_o(allocate_tblock_id_o),
        .tblock_done_i(tblock_done_i), .tblock_done_id_i(tblock_done_id_i),
        .tblock_done_ready_o(tblock_done_ready_o), .busy_o(busy_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_alloc(input string tag, input int idx, input int id);
        chk({tag, "_warp"}, 64'(allocate_warp_o), 64'd1);
        chk({tag, "_idx"},  64'(allocate_tblock_idx_o), 64'(idx));
        chk({tag, "_id"},   64'(allocate_tblock_id_o), 64'(id));
    endtask

    function automatic logic [63:0] exp_stall(input int n);
`ifdef BGPU_DISPATCH_PERF_EN
        return 64'(n);
`else
        return 64'(n * 0);
`endif
    endfunction

    task automatic launch(input int num, input logic [31:0] pc, input logic [31:0] dp);
        launch_valid_i       = 1'b1;
        launch_num_tblocks_i = (IdxB+1)'(num);
        launch_pc_i          = pc;
        launch_dp_addr_i     = dp;
    endtask

    initial begin
        rst_i = 1'b1; launch_valid_i = 1'b0; launch_pc_i = '0; launch_dp_addr_i = '0;
        launch_num_tblocks_i = '0; grid_done_ready_i = 1'b0; warp_free_i = 1'b1;
        tblock_done_i = 1'b0; tblock_done_id_i = '0;

        // reset: every output low, even with warp_free asserted
        cyc(); cyc(); #2;
        chk("rst_launch_ready", 64'(launch_ready_o), 64'd0);
        chk("rst_alloc", 64'(allocate_warp_o), 64'd0);
        chk("rst_done_ready", 64'(tblock_done_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        cyc(); rst_i = 1'b0; warp_free_i = 1'b0; #2;
        chk("idle_launch_ready", 64'(launch_ready_o), 64'd1);
        chk("idle_done_ready", 64'(tblock_done_ready_o), 64'd1);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_grid_done", 64'(grid_done_valid_o), 64'd0);

        // basic grid of 3
        launch(3, 32'h100, 32'h2000); warp_free_i = 1'b1; #2;
        chk("s1_launch_ready", 64'(launch_ready_o), 64'd1);
        cyc(); launch_valid_i = 1'b0; #2;
        chk_alloc("s1_a0", 0, 0);
        chk("s1_pc", 64'(allocate_pc_o), 64'h100);
        chk("s1_dp", 64'(allocate_dp_addr_o), 64'h2000);
        chk("s1_busy", 64'(busy_o), 64'd1);
        cyc(); #2; chk_alloc("s1_a1", 1, 1);
        cyc(); #2; chk_alloc("s1_a2", 2, 2);
        cyc(); #2;
        chk("s1_drain_noalloc", 64'(allocate_warp_o), 64'd0);
        chk("s1_drain_pc_zero", 64'(allocate_pc_o), 64'd0);
        tblock_done_i = 1'b1; tblock_done_id_i = 2'd1;
        cyc(); tblock_done_id_i = 2'd0;
        cyc(); tblock_done_id_i = 2'd2; #2;
        chk("s1_grid_not_yet", 64'(grid_done_valid_o), 64'd0);
        cyc(); tblock_done_i = 1'b0; #2;
        chk("s1_drain_registered", 64'(grid_done_valid_o), 64'd0);
        cyc(); #2;
        chk("s1_grid_done", 64'(grid_done_valid_o), 64'd1);
        cyc(); #2;
        chk("s1_grid_hold", 64'(grid_done_valid_o), 64'd1);
        chk("s1_done_no_launch", 64'(launch_ready_o), 64'd0);
        grid_done_ready_i = 1'b1;
        cyc(); grid_done_ready_i = 1'b0; #2;
        chk("s1_back_idle", 64'(busy_o), 64'd0);
        chk("s1_grid_clear", 64'(grid_done_valid_o), 64'd0);

        // id exhaustion: 6 blocks through a 4-entry pool
        launch(6, 32'h400, 32'h3000);
        cyc(); launch_valid_i = 1'b0; #2; chk_alloc("s2_a0", 0, 0);
        cyc(); #2; chk_alloc("s2_a1", 1, 1);
        cyc(); #2; chk_alloc("s2_a2", 2, 2);
        cyc(); #2; chk_alloc("s2_a3", 3, 3);
        cyc(); #2; chk("s2_full", 64'(allocate_warp_o), 64'd0);
        cyc(); tblock_done_i = 1'b1; tblock_done_id_i = 2'd2; #2;
        chk("s2_free_not_same_cycle", 64'(allocate_warp_o), 64'd0);
        cyc(); tblock_done_i = 1'b0; #2; chk_alloc("s2_a4", 4, 2);
        cyc(); #2; chk("s2_full_again", 64'(allocate_warp_o), 64'd0);
        tblock_done_i = 1'b1; tblock_done_id_i = 2'd0;
        cyc(); tblock_done_i = 1'b0; #2; chk_alloc("s2_a5", 5, 0);
        cyc(); #2;
        chk("s2_stall", 64'(stall_cycles_o), exp_stall(3));
        tblock_done_i = 1'b1; tblock_done_id_i = 2'd1;
        cyc(); tblock_done_id_i = 2'd3;
        cyc(); tblock_done_id_i = 2'd0;
        cyc(); tblock_done_id_i = 2'd2;
        cyc(); tblock_done_i = 1'b0; #2;
        chk("s2_drain", 64'(grid_done_valid_o), 64'd0);
        cyc(); #2; chk("s2_grid_done", 64'(grid_done_valid_o), 64'd1);
        grid_done_ready_i = 1'b1;
        cyc(); grid_done_ready_i = 1'b0;

        // simultaneous allocation of idx 3 and completion of id 0
        launch(6, 32'h500, 32'h4000);
        cyc(); launch_valid_i = 1'b0; #2; chk_alloc("s3_a0", 0, 0);
        cyc(); #2; chk_alloc("s3_a1", 1, 1);
        cyc(); #2; chk_alloc("s3_a2", 2, 2);
        cyc(); tblock_done_i = 1'b1; tblock_done_id_i = 2'd0; #2;
        chk_alloc("s3_a3_simul", 3, 3);
        cyc(); tblock_done_i = 1'b0; #2; chk_alloc("s3_a4_reuse", 4, 0);
        cyc(); #2; chk("s3_full", 64'(allocate_warp_o), 64'd0);
        tblock_done_i = 1'b1; tblock_done_id_i = 2'd1;
        cyc(); tblock_done_i = 1'b0; #2; chk_alloc("s3_a5", 5, 1);
        cyc(); tblock_done_i = 1'b1; tblock_done_id_i = 2'd0;
        cyc(); tblock_done_id_i = 2'd2;
        cyc(); tblock_done_id_i = 2'd3;
        cyc(); tblock_done_id_i = 2'd1; #2;
        chk("s3_last_done", 64'(grid_done_valid_o), 64'd0);
        cyc(); tblock_done_i = 1'b0; #2;
        chk("s3_outstanding_kept", 64'(grid_done_valid_o), 64'd0);
        cyc(); #2; chk("s3_grid_done", 64'(grid_done_valid_o), 64'd1);
        grid_done_ready_i = 1'b1;
        cyc(); grid_done_ready_i = 1'b0;

        // zero-size grid
        launch(0, 32'h0, 32'h0);
        cyc(); launch_valid_i = 1'b0; #2;
        chk("s4_grid_done", 64'(grid_done_valid_o), 64'd1);
        chk("s4_no_alloc", 64'(allocate_warp_o), 64'd0);
        grid_done_ready_i = 1'b1;
        cyc(); grid_done_ready_i = 1'b0; #2;
        chk("s4_idle", 64'(launch_ready_o), 64'd1);

        // backpressure then reset mid-dispatch
        launch(3, 32'h600, 32'h5000); warp_free_i = 1'b0;
        cyc(); launch_valid_i = 1'b0; #2;
        chk("s5_bp0", 64'(allocate_warp_o), 64'd0);
        for (int k = 1; k < 5; k++) begin
            cyc(); #2;
            chk("s5_bp", 64'(allocate_warp_o), 64'd0);
        end
        cyc(); warp_free_i = 1'b1; #2;
        chk_alloc("s5_a0", 0, 0);
        chk("s5_stall", 64'(stall_cycles_o), exp_stall(5));
        cyc(); #2; chk_alloc("s5_a1", 1, 1);
        cyc(); rst_i = 1'b1; #2;
        chk("s5_rst_alloc", 64'(allocate_warp_o), 64'd0);
        chk("s5_rst_done_ready", 64'(tblock_done_ready_o), 64'd0);
        chk("s5_rst_launch_ready", 64'(launch_ready_o), 64'd0);
        cyc(); rst_i = 1'b0; #2;
        chk("s5_post_rst_busy", 64'(busy_o), 64'd0);
        chk("s5_post_rst_ready", 64'(launch_ready_o), 64'd1);
        launch(2, 32'h700, 32'h6000);
        cyc(); launch_valid_i = 1'b0; #2;
        chk_alloc("s5_r0", 0, 0);
        chk("s5_r0_pc", 64'(allocate_pc_o), 64'h700);
        cyc(); #2; chk_alloc("s5_r1", 1, 1);
        cyc(); tblock_done_i = 1'b1; tblock_done_id_i = 2'd0;
        cyc(); tblock_done_id_i = 2'd1;
        cyc(); tblock_done_i = 1'b0;
        cyc(); #2; chk("s5_grid_done", 64'(grid_done_valid_o), 64'd1);
        grid_done_ready_i = 1'b1;
        cyc(); grid_done_ready_i = 1'b0; #2;
        chk("s5_final_idle", 64'(busy_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
